fpu_req_arbiter: RTL and testbench

- Shares one FPU block pipeline between NUM_REQS requesters, e.g. issue slots or sub-cores contending for one FPU block.
- Round-robin grants requests and allocates a unique in-flight tag per request from a free list.
- Caps outstanding operations per requester.
- Routes each FPU response back to its owning requester by tag lookup.
- Sits between the dispatch side and the per-block FPU datapath (DPI/FPNEW/DSP) in place of a direct connection.

---
 rtl/fpu_req_arbiter_if.sv | 56 +++++
 rtl/fpu_req_arbiter.sv | 149 ++++++++++++++
 tb/tb_fpu_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_req_arbiter_if.sv
// Signal bundle between the dispatch requesters, the arbiter and the shared FPU pipeline.
// The arbiter uses the slave modport; the surrounding environment uses the master modport.
interface fpu_req_arbiter_if #(
    parameter int NUM_REQS    = 4,
    parameter int REQ_DATAW   = 256,
    parameter int RSP_DATAW   = 133,
    parameter int TAG_SIZE    = 8,
    parameter int MAX_PENDING = 4,
    parameter int TAG_WIDTH   = (TAG_SIZE > 1) ? $clog2(TAG_SIZE) : 1,
    parameter int CNT_WIDTH   = $clog2(MAX_PENDING + 1)
);
    logic [NUM_REQS-1:0]           req_valid;
    logic [NUM_REQS*REQ_DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]           req_ready;

    logic                          fpu_req_valid;
    logic [REQ_DATAW-1:0]          fpu_req_data;
    logic [TAG_WIDTH-1:0]          fpu_req_tag;
    logic                          fpu_req_ready;

    logic                          fpu_rsp_valid;
    logic [RSP_DATAW-1:0]          fpu_rsp_data;
    logic [TAG_WIDTH-1:0]          fpu_rsp_tag;
    logic                          fpu_rsp_ready;

    logic [NUM_REQS-1:0]           rsp_valid;
    logic [RSP_DATAW-1:0]          rsp_data;
    logic [NUM_REQS-1:0]           rsp_ready;

    logic [NUM_REQS*CNT_WIDTH-1:0] pending_cnt;
    logic                          idle;

    modport slave (
        input  req_valid, req_data,
        output req_ready,
        output fpu_req_valid, fpu_req_data, fpu_req_tag,
        input  fpu_req_ready,
        input  fpu_rsp_valid, fpu_rsp_data, fpu_rsp_tag,
        output fpu_rsp_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output pending_cnt, idle
    );

    modport master (
        output req_valid, req_data,
        input  req_ready,
        input  fpu_req_valid, fpu_req_data, fpu_req_tag,
        output fpu_req_ready,
        output fpu_rsp_valid, fpu_rsp_data, fpu_rsp_tag,
        input  fpu_rsp_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  pending_cnt, idle
    );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one FPU pipeline between NUM_REQS requesters, with tag
// allocation from a free list, a per-requester in-flight cap and tag-based response routing.
module fpu_req_arbiter #(
    parameter int NUM_REQS    = 4,
    parameter int REQ_DATAW   = 256,
    parameter int RSP_DATAW   = 133,
    parameter int TAG_SIZE    = 8,
    parameter int MAX_PENDING = 4,
    parameter int TAG_WIDTH   = (TAG_SIZE > 1) ? $clog2(TAG_SIZE) : 1,
    parameter int CNT_WIDTH   = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    fpu_req_arbiter_if.slave bus
);
    localparam int OWN_WIDTH = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    typedef logic [OWN_WIDTH-1:0] own_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    logic [TAG_SIZE-1:0]  free_mask;
    logic [TAG_SIZE-1:0]  free_mask_next;
    own_t                 owner [TAG_SIZE];
    own_t                 rr_ptr;
    own_t                 rr_ptr_next;
    cnt_t                 cnt [NUM_REQS];
    cnt_t                 cnt_next [NUM_REQS];

    logic [NUM_REQS-1:0]  eligible;
    logic [NUM_REQS-1:0]  inc;
    logic [NUM_REQS-1:0]  dec;
    logic [NUM_REQS-1:0]  req_ready_w;
    logic [NUM_REQS-1:0]  rsp_valid_w;
    logic [TAG_WIDTH-1:0] alloc_tag;
    own_t                 grant;
    own_t                 cand;
    own_t                 own;
    logic                 found;
    logic                 tag_avail;
    logic                 req_fire;
    logic                 rsp_busy;
    logic                 rsp_fire;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = bus.req_valid[i] && (cnt[i] < cnt_t'(MAX_PENDING));
        end
    end

    // Descending scan so the lowest free tag is the last one written.
    always_comb begin
        alloc_tag = '0;
        for (int t = TAG_SIZE - 1; t >= 0; t--) begin
            if (free_mask[t]) alloc_tag = TAG_WIDTH'(t);
        end
    end

    always_comb begin
        grant = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = own_t'((int'(rr_ptr) + k) % NUM_REQS);
            if (!found && eligible[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    assign tag_avail         = |free_mask;
    assign bus.fpu_req_valid = (|eligible) && tag_avail;
    assign bus.fpu_req_data  = bus.req_data[int'(grant)*REQ_DATAW +: REQ_DATAW];
    assign bus.fpu_req_tag   = alloc_tag;
    assign req_fire          = bus.fpu_req_valid && bus.fpu_req_ready;

    always_comb begin
        req_ready_w = '0;
        if (req_fire) req_ready_w[grant] = 1'b1;
    end
    assign bus.req_ready = req_ready_w;

    // A response carrying a free tag has no owner; it is swallowed without touching state.
    assign own               = owner[bus.fpu_rsp_tag];
    assign rsp_busy          = !free_mask[bus.fpu_rsp_tag];
    assign bus.fpu_rsp_ready = rsp_busy ? bus.rsp_ready[own] : 1'b1;
    assign rsp_fire          = bus.fpu_rsp_valid && rsp_busy && bus.rsp_ready[own];
    assign bus.rsp_data      = bus.fpu_rsp_data;

    always_comb begin
        rsp_valid_w = '0;
        if (bus.fpu_rsp_valid && rsp_busy) rsp_valid_w[own] = 1'b1;
    end
    assign bus.rsp_valid = rsp_valid_w;

    // Allocation uses the registered mask, so a tag freed this cycle only becomes visible next cycle.
    always_comb begin
        free_mask_next = free_mask;
        if (req_fire) free_mask_next[alloc_tag] = 1'b0;
        if (rsp_fire) free_mask_next[bus.fpu_rsp_tag] = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            inc[i]      = req_fire && (grant == own_t'(i));
            dec[i]      = rsp_fire && (own == own_t'(i));
            cnt_next[i] = cnt[i];
            if (inc[i] && !dec[i]) cnt_next[i] = cnt[i] + 1'b1;
            if (dec[i] && !inc[i]) cnt_next[i] = cnt[i] - 1'b1;
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr;
        if (req_fire) rr_ptr_next = (int'(grant) == NUM_REQS - 1) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            free_mask <= '1;
            rr_ptr    <= '0;
            for (int i = 0; i < NUM_REQS; i++) cnt[i] <= '0;
        end else begin
            free_mask <= free_mask_next;
            rr_ptr    <= rr_ptr_next;
            for (int i = 0; i < NUM_REQS; i++) cnt[i] <= cnt_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) owner[alloc_tag] <= grant;
    end

    always_comb begin
        bus.pending_cnt = '0;
        for (int i = 0; i < NUM_REQS; i++) bus.pending_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
    end
    assign bus.idle = &free_mask;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(bus.fpu_rsp_valid && !rsp_busy));
            for (int i = 0; i < NUM_REQS; i++) begin
                assert (!(inc[i] && !dec[i] && cnt[i] >= cnt_t'(MAX_PENDING)));
                assert (!(dec[i] && !inc[i] && cnt[i] == '0));
            end
        end
    end
endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter: stimulus pushes expected fires into queues,
// a negedge monitor pops and compares each request and response handshake.
module tb_fpu_req_arbiter;
    localparam int NUM_REQS    = 4;
    localparam int REQ_DATAW   = 256;
    localparam int RSP_DATAW   = 133;
    localparam int TAG_SIZE    = 8;
    localparam int MAX_PENDING = 4;
    localparam int TAG_WIDTH   = 3;
    localparam int CNT_WIDTH   = 3;

    typedef struct {
        int idx;
        int tag;
    } req_exp_t;

    typedef struct {
        logic [NUM_REQS-1:0]  onehot;
        logic [RSP_DATAW-1:0] data;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vec_count = 0;
    int   miscompares = 0;

    req_exp_t req_q[$];
    rsp_exp_t rsp_q[$];
    req_exp_t mon_req;
    rsp_exp_t mon_rsp;

    fpu_req_arbiter_if #(
        .NUM_REQS(NUM_REQS), .REQ_DATAW(REQ_DATAW), .RSP_DATAW(RSP_DATAW),
        .TAG_SIZE(TAG_SIZE), .MAX_PENDING(MAX_PENDING),
        .TAG_WIDTH(TAG_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) bus ();

    fpu_req_arbiter #(
        .NUM_REQS(NUM_REQS), .REQ_DATAW(REQ_DATAW), .RSP_DATAW(RSP_DATAW),
        .TAG_SIZE(TAG_SIZE), .MAX_PENDING(MAX_PENDING),
        .TAG_WIDTH(TAG_WIDTH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [REQ_DATAW-1:0] mk_req(int i);
        logic [REQ_DATAW-1:0] v;
        v = '0;
        v[255:248] = 8'hA0 + 8'(i);
        v[31:0]    = 32'hC0DE0000 + 32'(i);
        return v;
    endfunction

    function automatic logic [RSP_DATAW-1:0] mk_rsp(logic [TAG_WIDTH-1:0] t);
        logic [RSP_DATAW-1:0] v;
        v = '0;
        v[132:128] = 5'h15;
        v[15:0]    = 16'hD000 + 16'(t);
        return v;
    endfunction

    task automatic pushReq(int idx, int tag);
        req_exp_t e;
        e.idx = idx;
        e.tag = tag;
        req_q.push_back(e);
    endtask

    task automatic pushRsp(logic [NUM_REQS-1:0] onehot, logic [TAG_WIDTH-1:0] tag);
        rsp_exp_t e;
        e.onehot = onehot;
        e.data   = mk_rsp(tag);
        rsp_q.push_back(e);
    endtask

    task automatic applyStimulus(logic [NUM_REQS-1:0] rv, logic frr, logic frv,
                                 logic [TAG_WIDTH-1:0] ftag, logic [NUM_REQS-1:0] rr);
        @(posedge clk);
        #1;
        bus.req_valid     = rv;
        bus.fpu_req_ready = frr;
        bus.fpu_rsp_valid = frv;
        bus.fpu_rsp_tag   = ftag;
        bus.fpu_rsp_data  = mk_rsp(ftag);
        bus.rsp_ready     = rr;
    endtask

    task automatic doReset(int n);
        @(posedge clk);
        #1;
        reset_n           = 1'b0;
        bus.req_valid     = '0;
        bus.fpu_req_ready = 1'b0;
        bus.fpu_rsp_valid = 1'b0;
        bus.fpu_rsp_tag   = '0;
        bus.rsp_ready     = '0;
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every handshake on either side must match the next queued expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.fpu_req_valid && bus.fpu_req_ready) begin
                vec_count++;
                if (req_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL req_fire: unexpected fire ready=%b tag=%0d, required no fire",
                             bus.req_ready, bus.fpu_req_tag);
                end else begin
                    mon_req = req_q.pop_front();
                    if (bus.fpu_req_tag !== TAG_WIDTH'(mon_req.tag) ||
                        bus.fpu_req_data !== mk_req(mon_req.idx) ||
                        bus.req_ready !== NUM_REQS'(1 << mon_req.idx)) begin
                        miscompares++;
                        $display("[TB] FAIL req_fire: got ready=%b tag=%0d data=%h, expected ready=%b tag=%0d data=%h",
                                 bus.req_ready, bus.fpu_req_tag, bus.fpu_req_data[31:0],
                                 NUM_REQS'(1 << mon_req.idx), mon_req.tag, mk_req(mon_req.idx)[31:0]);
                    end
                end
            end
            if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
                vec_count++;
                if (rsp_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL rsp_fire: unexpected rsp_valid=%b, required none", bus.rsp_valid);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    if (bus.rsp_valid !== mon_rsp.onehot || bus.rsp_data !== mon_rsp.data ||
                        bus.fpu_rsp_ready !== 1'b1) begin
                        miscompares++;
                        $display("[TB] FAIL rsp_fire: got valid=%b data=%h fpu_rsp_ready=%b, expected valid=%b data=%h fpu_rsp_ready=1",
                                 bus.rsp_valid, bus.rsp_data[15:0], bus.fpu_rsp_ready,
                                 mon_rsp.onehot, mon_rsp.data[15:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < NUM_REQS; i++) bus.req_data[i*REQ_DATAW +: REQ_DATAW] = mk_req(i);
        bus.req_valid     = '0;
        bus.fpu_req_ready = 1'b0;
        bus.fpu_rsp_valid = 1'b0;
        bus.fpu_rsp_tag   = '0;
        bus.fpu_rsp_data  = '0;
        bus.rsp_ready     = '0;

        // Reset and idle
        doReset(2);
        @(negedge clk);
        checkOutput("reset_idle", 32'(bus.idle), 1);
        checkOutput("reset_fpu_req_valid", 32'(bus.fpu_req_valid), 0);
        checkOutput("reset_pending", 32'(bus.pending_cnt), 0);
        checkOutput("reset_req_ready", 32'(bus.req_ready), 0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 0);

        // fpu_req_valid must not wait for fpu_req_ready
        applyStimulus(4'b0001, 1'b0, 1'b0, 3'd0, 4'b0000);
        @(negedge clk);
        checkOutput("noready_valid", 32'(bus.fpu_req_valid), 1);
        checkOutput("noready_req_ready", 32'(bus.req_ready), 0);
        checkOutput("noready_tag", 32'(bus.fpu_req_tag), 0);

        // Round-robin until tags run out
        for (int k = 0; k < 8; k++) pushReq(k % 4, k);
        applyStimulus(4'b1111, 1'b1, 1'b0, 3'd0, 4'b1111);
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput("full_fpu_req_valid", 32'(bus.fpu_req_valid), 0);
        checkOutput("full_req_ready", 32'(bus.req_ready), 0);
        checkOutput("full_pending", 32'(bus.pending_cnt), 1170);
        checkOutput("full_idle", 32'(bus.idle), 0);

        // Per-requester cap
        doReset(1);
        for (int k = 0; k < 4; k++) pushReq(2, k);
        applyStimulus(4'b0100, 1'b1, 1'b0, 3'd0, 4'b1111);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("cap_req_ready", 32'(bus.req_ready), 0);
        checkOutput("cap_fpu_req_valid", 32'(bus.fpu_req_valid), 0);
        checkOutput("cap_pending", 32'(bus.pending_cnt), 256);
        pushReq(0, 4);
        applyStimulus(4'b0101, 1'b1, 1'b0, 3'd0, 4'b1111);
        @(negedge clk);
        checkOutput("cap_other_ready", 32'(bus.req_ready), 4'b0001);
        checkOutput("cap_other_tag", 32'(bus.fpu_req_tag), 4);
        applyStimulus(4'b0000, 1'b1, 1'b0, 3'd0, 4'b1111);
        @(negedge clk);
        checkOutput("cap_pending_after", 32'(bus.pending_cnt), 257);

        // Out-of-order response routing
        doReset(1);
        pushReq(1, 0);
        applyStimulus(4'b0010, 1'b1, 1'b0, 3'd0, 4'b1111);
        pushReq(3, 1);
        applyStimulus(4'b1000, 1'b1, 1'b0, 3'd0, 4'b1111);
        pushReq(0, 2);
        applyStimulus(4'b0001, 1'b1, 1'b0, 3'd0, 4'b1111);
        applyStimulus(4'b0000, 1'b1, 1'b0, 3'd0, 4'b1111);
        @(negedge clk);
        checkOutput("ooo_pending", 32'(bus.pending_cnt), 521);
        pushRsp(4'b0001, 3'd2);
        applyStimulus(4'b0000, 1'b1, 1'b1, 3'd2, 4'b1111);
        pushRsp(4'b0010, 3'd0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 3'd0, 4'b1111);
        pushRsp(4'b1000, 3'd1);
        applyStimulus(4'b0000, 1'b1, 1'b1, 3'd1, 4'b1111);
        applyStimulus(4'b0000, 1'b1, 1'b0, 3'd0, 4'b1111);
        @(negedge clk);
        checkOutput("ooo_pending_after", 32'(bus.pending_cnt), 0);
        checkOutput("ooo_idle", 32'(bus.idle), 1);

        // Backpressure and same-cycle request/response on one requester
        doReset(1);
        for (int k = 0; k < 6; k++) pushReq(k % 4, k);
        applyStimulus(4'b1111, 1'b1, 1'b0, 3'd0, 4'b1111);
        repeat (5) @(posedge clk);
        pushReq(2, 6);
        applyStimulus(4'b0100, 1'b1, 1'b1, 3'd5, 4'b1101);
        @(negedge clk);
        checkOutput("bp_fpu_rsp_ready", 32'(bus.fpu_rsp_ready), 0);
        checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 4'b0010);
        checkOutput("bp_req_ready", 32'(bus.req_ready), 4'b0100);
        pushReq(1, 7);
        pushRsp(4'b0010, 3'd5);
        applyStimulus(4'b0010, 1'b1, 1'b1, 3'd5, 4'b1111);
        @(negedge clk);
        checkOutput("same_req_ready", 32'(bus.req_ready), 4'b0010);
        checkOutput("same_tag_not_reused", 32'(bus.fpu_req_tag), 7);
        pushReq(1, 5);
        applyStimulus(4'b0010, 1'b1, 1'b0, 3'd0, 4'b1111);
        @(negedge clk);
        checkOutput("same_pending_unchanged", 32'(bus.pending_cnt), 658);
        checkOutput("freed_tag_next_cycle", 32'(bus.fpu_req_tag), 5);
        applyStimulus(4'b0000, 1'b1, 1'b0, 3'd0, 4'b1111);
        @(negedge clk);
        checkOutput("bp_pending_final", 32'(bus.pending_cnt), 666);

        // Reset with six operations in flight
        doReset(1);
        for (int k = 0; k < 6; k++) pushReq(k % 4, k);
        applyStimulus(4'b1111, 1'b1, 1'b0, 3'd0, 4'b1111);
        repeat (5) @(posedge clk);
        doReset(1);
        @(negedge clk);
        checkOutput("midrst_idle", 32'(bus.idle), 1);
        checkOutput("midrst_pending", 32'(bus.pending_cnt), 0);
        checkOutput("midrst_fpu_req_valid", 32'(bus.fpu_req_valid), 0);
        pushReq(1, 0);
        applyStimulus(4'b0110, 1'b1, 1'b0, 3'd0, 4'b1111);
        @(negedge clk);
        checkOutput("midrst_grant", 32'(bus.req_ready), 4'b0010);
        checkOutput("midrst_tag", 32'(bus.fpu_req_tag), 0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 3'd0, 4'b1111);
        repeat (2) @(posedge clk);
        @(negedge clk);

        checkOutput("req_queue_drained", 32'(req_q.size()), 0);
        checkOutput("rsp_queue_drained", 32'(rsp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
